// File: rtl/ccm_prog.sv
// Run-time programmable 3x3 colour correction matrix with double-buffered coefficients.
// Optional per-channel offsets enabled by defining CCM_OFFSET_EN.
module ccm_prog #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 12,
  parameter int unsigned FRAC_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_vsync,
  input  logic              in_hsync,
  input  logic              in_den,
  input  logic [DATA_W-1:0] in_data_R,
  input  logic [DATA_W-1:0] in_data_G,
  input  logic [DATA_W-1:0] in_data_B,
  input  logic              bypass,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [COEF_W-1:0] cfg_wdata,
  input  logic              cfg_commit,
  output logic              cfg_pending,
  output logic              out_vsync,
  output logic              out_hsync,
  output logic              out_den,
  output logic [DATA_W-1:0] out_data_R,
  output logic [DATA_W-1:0] out_data_G,
  output logic [DATA_W-1:0] out_data_B
);

  localparam int unsigned PW = DATA_W + COEF_W + 1;
  localparam int unsigned SW = PW + 2;
  localparam int unsigned VW = SW + 1;
`ifdef CCM_OFFSET_EN
  localparam int unsigned NREG = 12;
`else
  localparam int unsigned NREG = 9;
`endif
  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1 << FRAC_W);
  localparam logic signed [SW-1:0]     RND      = SW'(1 << (FRAC_W - 1));

  logic signed [COEF_W-1:0] shadow_q [NREG];
  logic signed [COEF_W-1:0] shadow_d [NREG];
  logic signed [COEF_W-1:0] active_q [NREG];
  logic                     vsync_d;
  logic                     vsync_rise;

  logic [DATA_W-1:0]        s1_px [3];
  logic [DATA_W-1:0]        s2_px [3];
  logic [DATA_W-1:0]        s3_px [3];
  logic [2:0]               s1_ctl, s2_ctl, s3_ctl;
  logic                     s1_byp, s2_byp, s3_byp;
  logic signed [PW-1:0]     s2_prod [9];
  logic signed [SW-1:0]     s3_sum [3];
  logic signed [VW-1:0]     v [3];
  logic [DATA_W-1:0]        res [3];

  function automatic logic signed [COEF_W-1:0] ident(input int i);
    return (i == 0 || i == 4 || i == 8) ? COEF_ONE : '0;
  endfunction

  // Unsigned pixel times signed coefficient, exact in PW bits.
  function automatic logic signed [PW-1:0] mul(input logic [DATA_W-1:0] px,
                                               input logic signed [COEF_W-1:0] c);
    logic signed [PW-1:0] a;
    logic signed [PW-1:0] b;
    a = $signed({{(PW-DATA_W){1'b0}}, px});
    b = $signed({{(PW-COEF_W){c[COEF_W-1]}}, c});
    return a * b;
  endfunction

  function automatic logic signed [SW-1:0] sx(input logic signed [PW-1:0] p);
    return $signed({{(SW-PW){p[PW-1]}}, p});
  endfunction

  assign vsync_rise = in_vsync & ~vsync_d;

  // Shadow bank with this cycle's write folded in, so a coincident copy sees it.
  always_comb begin
    for (int i = 0; i < int'(NREG); i++) begin
      shadow_d[i] = shadow_q[i];
      if (cfg_we && (cfg_addr == 4'(i))) shadow_d[i] = cfg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_d     <= 1'b0;
      cfg_pending <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) begin
        shadow_q[i] <= ident(i);
        active_q[i] <= ident(i);
      end
    end else begin
      vsync_d  <= in_vsync;
      shadow_q <= shadow_d;
      if (vsync_rise && (cfg_pending || cfg_commit)) begin
        active_q    <= shadow_d;
        cfg_pending <= 1'b0;
      end else if (cfg_commit) begin
        cfg_pending <= 1'b1;
      end
    end
  end

  // Arithmetic shift, optional offset, then clamp to the output range.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      v[r] = $signed({s3_sum[r][SW-1], s3_sum[r]}) >>> FRAC_W;
`ifdef CCM_OFFSET_EN
      v[r] = v[r] + $signed({{(VW-COEF_W){active_q[9+r][COEF_W-1]}}, active_q[9+r]});
`endif
      if (v[r][VW-1])               res[r] = '0;
      else if (|v[r][VW-2:DATA_W])  res[r] = '1;
      else                          res[r] = v[r][DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < 3; c++) begin
        s1_px[c]  <= '0;
        s2_px[c]  <= '0;
        s3_px[c]  <= '0;
        s3_sum[c] <= '0;
      end
      for (int k = 0; k < 9; k++) s2_prod[k] <= '0;
      s1_ctl     <= '0;
      s2_ctl     <= '0;
      s3_ctl     <= '0;
      s1_byp     <= 1'b0;
      s2_byp     <= 1'b0;
      s3_byp     <= 1'b0;
      out_vsync  <= 1'b0;
      out_hsync  <= 1'b0;
      out_den    <= 1'b0;
      out_data_R <= '0;
      out_data_G <= '0;
      out_data_B <= '0;
    end else begin
      s1_px[0] <= in_data_R;
      s1_px[1] <= in_data_G;
      s1_px[2] <= in_data_B;
      s1_ctl   <= {in_vsync, in_hsync, in_den};
      s1_byp   <= bypass;

      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          s2_prod[3*r+c] <= mul(s1_px[c], active_q[3*r+c]);
      s2_px  <= s1_px;
      s2_ctl <= s1_ctl;
      s2_byp <= s1_byp;

      for (int r = 0; r < 3; r++)
        s3_sum[r] <= sx(s2_prod[3*r]) + sx(s2_prod[3*r+1]) + sx(s2_prod[3*r+2]) + RND;
      s3_px  <= s2_px;
      s3_ctl <= s2_ctl;
      s3_byp <= s2_byp;

      out_vsync  <= s3_ctl[2];
      out_hsync  <= s3_ctl[1];
      out_den    <= s3_ctl[0];
      out_data_R <= s3_byp ? s3_px[0] : res[0];
      out_data_G <= s3_byp ? s3_px[1] : res[1];
      out_data_B <= s3_byp ? s3_px[2] : res[2];
    end
  end

endmodule

// File: tb/tb_ccm_prog.sv
// Self-checking bench for ccm_prog: vector table plus hand sequences, scoreboard-checked outputs.
module tb_ccm_prog;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned COEF_W = 12;
  localparam int unsigned FRAC_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_vsync, in_hsync, in_den;
  logic [DATA_W-1:0] in_data_R, in_data_G, in_data_B;
  logic              bypass;
  logic              cfg_we;
  logic [3:0]        cfg_addr;
  logic [COEF_W-1:0] cfg_wdata;
  logic              cfg_commit;
  logic              cfg_pending;
  logic              out_vsync, out_hsync, out_den;
  logic [DATA_W-1:0] out_data_R, out_data_G, out_data_B;

  ccm_prog #(.DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .reset(reset),
    .in_vsync(in_vsync), .in_hsync(in_hsync), .in_den(in_den),
    .in_data_R(in_data_R), .in_data_G(in_data_G), .in_data_B(in_data_B),
    .bypass(bypass),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .cfg_pending(cfg_pending),
    .out_vsync(out_vsync), .out_hsync(out_hsync), .out_den(out_den),
    .out_data_R(out_data_R), .out_data_G(out_data_G), .out_data_B(out_data_B)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] r, g, b;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] r, g, b;
    logic       byp;
    logic [7:0] er, eg, eb;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl [10];
  int   mat [9];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
               name, act, act, expv, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pix(input logic [7:0] r, g, b, er, eg, eb);
    exp_t e;
    in_data_R = r; in_data_G = g; in_data_B = b;
    in_den = 1'b1; in_hsync = 1'b1;
    e.r = er; e.g = eg; e.b = eb; e.cyc = cyc + 4;
    sbq.push_back(e);
    tick();
    in_den = 1'b0; in_hsync = 1'b0;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [COEF_W-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  // Frame start; also checks vsync latency through the pipe.
  task automatic vsync_pulse(input logic exp_pend_after);
    in_vsync = 1'b1;
    tick();
    chk("pend_after_vs", 32'(cfg_pending), 32'(exp_pend_after));
    idle(2);
    chk("ovs_early", 32'(out_vsync), 32'd0);
    tick();
    chk("ovs_lat4", 32'(out_vsync), 32'd1);
    in_vsync = 1'b0;
    idle(5);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() != 0; i++) tick();
    chk("drain_empty", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  // Scoreboard: every valid output pixel is matched against the next expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_den) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_den: got out_den=1 at cycle %0d, required no output", cyc);
      end else begin
        e = sbq.pop_front();
        chk("latency", 32'(cyc), 32'(e.cyc));
        chk("hsync_align", 32'(out_hsync), 32'd1);
        chk("pixel", 32'({out_data_R, out_data_G, out_data_B}), 32'({e.r, e.g, e.b}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish by 200000, required finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] r, g, b;
    mat = '{398, -30, -112, -58, 388, -74, -25, -112, 393};
    tbl[0] = '{8'd128, 8'd128, 8'd128, 1'b0, 8'd128, 8'd128, 8'd128};
    tbl[1] = '{8'd255, 8'd0,   8'd0,   1'b0, 8'd255, 8'd0,   8'd0};
    tbl[2] = '{8'd0,   8'd255, 8'd0,   1'b0, 8'd0,   8'd255, 8'd0};
    tbl[3] = '{8'd10,  8'd20,  8'd30,  1'b1, 8'd10,  8'd20,  8'd30};
    tbl[4] = '{8'd100, 8'd100, 8'd100, 1'b0, 8'd100, 8'd100, 8'd100};
    tbl[5] = '{8'd200, 8'd100, 8'd50,  1'b0, 8'd255, 8'd92,  8'd13};
    tbl[6] = '{8'd200, 8'd100, 8'd50,  1'b1, 8'd200, 8'd100, 8'd50};
    tbl[7] = '{8'd50,  8'd100, 8'd200, 1'b0, 8'd0,   8'd82,  8'd255};
    tbl[8] = '{8'd64,  8'd32,  8'd16,  1'b0, 8'd89,  8'd29,  8'd4};
    tbl[9] = '{8'd0,   8'd0,   8'd0,   1'b0, 8'd0,   8'd0,   8'd0};

    // Reset with busy inputs: everything must read zero.
    reset = 1'b1; in_vsync = 1'b1; in_hsync = 1'b1; in_den = 1'b1;
    in_data_R = 8'hff; in_data_G = 8'hff; in_data_B = 8'hff;
    bypass = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
    idle(3);
    chk("reset_outputs", 32'({out_vsync, out_hsync, out_den, out_data_R, out_data_G, out_data_B}), 32'd0);
    chk("reset_pending", 32'(cfg_pending), 32'd0);
    in_vsync = 1'b0; in_hsync = 1'b0; in_den = 1'b0;
    reset = 1'b0;
    idle(2);

    // Identity default, then a burst of back-to-back pixels.
    pix(8'd100, 8'd150, 8'd200, 8'd100, 8'd150, 8'd200);
    for (int i = 0; i < 8; i++) begin
      r = 8'($urandom_range(0, 255)); g = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
      pix(r, g, b, r, g, b);
    end
    drain();

    // Load matrix; out-of-range addresses must not land anywhere.
    for (int i = 0; i < 9; i++) cfg_write(4'(i), COEF_W'(mat[i]));
    cfg_write(4'd9, 12'd100);
    cfg_write(4'd15, 12'hfff);
    chk("pend_before_commit", 32'(cfg_pending), 32'd0);
    commit();
    chk("pend_after_commit", 32'(cfg_pending), 32'd1);
    pix(8'd50, 8'd60, 8'd70, 8'd50, 8'd60, 8'd70);
    drain();
    vsync_pulse(1'b0);

    for (int i = 0; i < 10; i++) begin
      bypass = tbl[i].byp;
      pix(tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].er, tbl[i].eg, tbl[i].eb);
    end
    bypass = 1'b0;
    drain();

    // Back to identity, then change rr mid-frame.
    for (int i = 0; i < 9; i++) cfg_write(4'(i), (i == 0 || i == 4 || i == 8) ? 12'd256 : 12'd0);
    commit();
    vsync_pulse(1'b0);
    cfg_write(4'd0, 12'd512);
    commit();
    pix(8'd100, 8'd50, 8'd25, 8'd100, 8'd50, 8'd25);
    chk("pend_midframe", 32'(cfg_pending), 32'd1);
    pix(8'd100, 8'd50, 8'd25, 8'd100, 8'd50, 8'd25);
    in_vsync = 1'b1;
    tick();
    chk("pend_cleared", 32'(cfg_pending), 32'd0);
    pix(8'd100, 8'd50, 8'd25, 8'd200, 8'd50, 8'd25);
    pix(8'd200, 8'd50, 8'd25, 8'd255, 8'd50, 8'd25);
    in_vsync = 1'b0;
    drain();

    // Write, commit and frame start all in one cycle.
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 12'd256; cfg_commit = 1'b1; in_vsync = 1'b1;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    chk("pend_same_cycle", 32'(cfg_pending), 32'd0);
    pix(8'd100, 8'd50, 8'd25, 8'd100, 8'd50, 8'd25);
    in_vsync = 1'b0;
    drain();
    idle(5);

    // Reset mid-line with a commit pending.
    cfg_write(4'd0, 12'd512);
    commit();
    chk("pend_pre_reset", 32'(cfg_pending), 32'd1);
    pix(8'd10, 8'd20, 8'd30, 8'd10, 8'd20, 8'd30);
    pix(8'd40, 8'd50, 8'd60, 8'd40, 8'd50, 8'd60);
    in_den = 1'b1; in_hsync = 1'b1;
    reset = 1'b1;
    tick();
    sbq.delete();
    in_den = 1'b0; in_hsync = 1'b0;
    reset = 1'b0;
    chk("reset_flush", 32'({out_hsync, out_den, out_data_R, out_data_G, out_data_B}), 32'd0);
    chk("reset_pend_lost", 32'(cfg_pending), 32'd0);
    tick();
    chk("reset_flush_pipe", 32'({out_hsync, out_den}), 32'd0);
    idle(4);
    vsync_pulse(1'b0);
    pix(8'd100, 8'd50, 8'd25, 8'd100, 8'd50, 8'd25);
    drain();
    commit();
    vsync_pulse(1'b0);
    pix(8'd120, 8'd60, 8'd30, 8'd120, 8'd60, 8'd30);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ccm_prog.md
Name: ccm_prog

Overview:
Parametrised, run-time programmable 3x3 colour correction matrix for the ISP RGB pipeline. It sits after demosaic/AWB and before gamma.
- Generalises the fixed-coefficient CCM: configurable data/coefficient widths, software-loadable signed coefficients, and a bypass mode.
- Coefficient updates are double-buffered and take effect only at a frame boundary, so a frame never tears mid-image.

Parameters:
DATA_W, 8, bits per colour channel (in and out)
COEF_W, 12, signed coefficient width (two's complement)
FRAC_W, 8, fractional bits of coefficient (1.0 = 1<<FRAC_W)

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
in_vsync  in  1  frame sync, active high
in_hsync  in  1  line sync
in_den  in  1  pixel valid
in_data_R / in_data_G / in_data_B  in  DATA_W each  input pixel
bypass  in  1  1 = pass pixels through unmodified (latency unchanged)
cfg_we  in  1  coefficient write strobe
cfg_addr  in  4  coefficient index
cfg_wdata  in  COEF_W  signed coefficient value
cfg_commit  in  1  single-cycle request to apply the shadow bank at the next frame start
cfg_pending  out  1  commit requested but not yet applied
out_vsync / out_hsync / out_den  out  1 each  delayed syncs
out_data_R / out_data_G / out_data_B  out  DATA_W each  corrected pixel

Behaviour:
- Reset, sampled on posedge clk while reset=1:
  - All outputs and pipeline registers go to 0; cfg_pending goes to 0.
  - Shadow and active banks load identity: addr 0, 4, 8 = 1<<FRAC_W; all others 0.
- Coefficient map, row-major: 0 rr, 1 rg, 2 rb, 3 gr, 4 gg, 5 gb, 6 br, 7 bg, 8 bb.
  - out_R = rr*R + rg*G + rb*B; the G and B rows follow the same pattern.
  - Writes with cfg_addr >= 9 are ignored (see Optional Feature for the exception).
- Writes: cfg_we writes cfg_wdata into the shadow bank only. The active bank is never written directly.
- Commit:
  - cfg_commit sets pending.
  - Frame-start edge: vsync_rise = in_vsync & ~vsync_d, where vsync_d is in_vsync registered.
  - When vsync_rise and pending are both 1, active <= shadow and pending clears.
  - cfg_commit and vsync_rise in the same cycle: the copy happens in that cycle.
  - cfg_we and the copy in the same cycle: the copy includes the newly written value.
  - cfg_commit while pending is already 1: no effect.
  - The new coefficients apply to every pixel entering on or after the cycle following vsync_rise.
- Pipeline: fixed latency of 4 clocks from input to output for data, vsync, hsync and den. It accepts one pixel per clock with no stalls.
  - S1: register the inputs and bypass.
  - S2: nine signed products. Inputs are zero-extended; each product is DATA_W+COEF_W+1 bits wide.
  - S3: per-row sum of three products plus rounding constant 1<<(FRAC_W-1), with 2 guard bits.
  - S4: arithmetic shift right by FRAC_W, then clamp. Negative results give 0; results above 2^DATA_W-1 give all-ones. Outputs are registered.
- Bypass: S4 outputs the S1-registered input instead of the clamped result. Syncs are unaffected.
- Pixels with den=0 still propagate through the pipeline. Output data is don't-care whenever out_den=0.
- Reset asserted mid-frame: the pipeline flushes to 0 and coefficients return to identity. Any pending commit is lost.

Optional Feature:
Macro: CCM_OFFSET_EN
- Defined:
  - cfg_addr 9, 10, 11 write signed per-channel offsets (R, G, B) into the shadow bank. These offsets are COEF_W wide, in integer pixel units, and reset to 0.
  - Offsets are committed together with the coefficients.
  - In S4 the offset is added after the shift and before the clamp.
- Not defined: addresses 9 to 11 are ignored, no offset logic is present, and results are bit-identical to an offset of 0.

Test Plan:
1. Release reset with defaults and drive (100,150,200), den=1 -> (100,150,200) appears exactly 4 clocks later with den aligned. All outputs are 0 during reset.
2. Load rr..bb = 398,-30,-112,-58,388,-74,-25,-112,393, commit, then pulse vsync. Input (128,128,128) -> (128,128,128); cfg_pending goes 1 -> 0 on the vsync edge.
3. Same matrix, input (255,0,0) -> R clamps 396 to 255; G (-14662) and B (-6247) clamp to 0, giving (255,0,0).
4. Identity active mid-frame: write addr0=512 and commit with vsync low. Input R=100 -> out R=100 until vsync rises; pixels after the rise -> R=200.
5. bypass=1 with the step-2 matrix, input (10,20,30) -> (10,20,30) after 4 clocks. Deasserting bypass -> the matrix result is used again.
6. Assert reset for 1 clock mid-line with pending=1 -> outputs are 0 on the next clock, pending is 0, and the following frame uses identity.
